// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-placement feeder and core.
// Contents: frame/coordinate constants, FSM state enum, point struct, and
// distance helpers used by the coverage checker.
package laser_pkg;

    localparam int unsigned NUM_POINTS = 40;
    localparam int unsigned RADIUS_SQ  = 16;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned IDX_W      = 6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        SCORE,
        REPORT
    } state_t;

    // Unsigned |a-b| without wrap-around.
    function automatic logic [COORD_W-1:0] abs_diff(logic [COORD_W-1:0] a,
                                                    logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Squared Euclidean distance; 9 bits hold the worst case 15^2 + 15^2 = 450.
    function automatic logic [8:0] dist_sq(point_t a, point_t b);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [7:0]         sx;
        logic [7:0]         sy;
        dx = abs_diff(a.x, b.x);
        dy = abs_diff(a.y, b.y);
        sx = {4'b0, dx} * {4'b0, dx};
        sy = {4'b0, dy} * {4'b0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage check: is a point within RADIUS_SQ (squared distance)
// of either of two circle centres.
// Ports:
//   pt      - point under test {x, y}
//   c1, c2  - circle centres {x, y}
//   covered - 1 if the point lies inside or on either circle
module laser_cover_chk
    import laser_pkg::*;
(
    input  logic [7:0] pt,
    input  logic [7:0] c1,
    input  logic [7:0] c2,
    output logic       covered
);

    point_t     p;
    point_t     a;
    point_t     b;
    logic [8:0] d1;
    logic [8:0] d2;

    assign p  = pt;
    assign a  = c1;
    assign b  = c2;
    assign d1 = dist_sq(p, a);
    assign d2 = dist_sq(p, b);

    // OR of the two tests so a point inside both circles counts once.
    assign covered = (d1 <= 9'(RADIUS_SQ)) || (d2 <= 9'(RADIUS_SQ));

endmodule

// File: rtl/laser_feeder.sv
// Point-stream transmitter and result collector for the laser-placement core.
// Holds a NUM_POINTS point set written by the host, streams it on X/Y one
// point per clock, waits for DONE, latches the two circle centres, then scores
// the answer by counting points covered by either circle.
// Ports:
//   CLK, RST                 - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_x/wr_y  - host point-memory write (accepted only in IDLE)
//   start                    - begin one frame (accepted only in IDLE)
//   X, Y                     - streamed point to the core (0 when not streaming)
//   C1X/C1Y/C2X/C2Y, DONE    - core result and result-valid
//   busy                     - frame in progress
//   score, score_valid       - covered count and its one-cycle valid pulse
//   timeout                  - qualifies score_valid: core never raised DONE
module laser_feeder
    import laser_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       start,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       busy,
    output logic [5:0] score,
    output logic       score_valid,
    output logic       timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         acc_q, acc_d;
    logic [5:0]         score_q, score_d;
    logic               timeout_q, timeout_d;
    point_t             c1_q, c1_d;
    point_t             c2_q, c2_d;

    point_t             mem [NUM_POINTS];
    point_t             pt0;
    point_t             rd_pt;
    logic [IDX_W-1:0]   rd_idx;
    logic               covered;

    // Point memory, deliberately not reset; writes only while idle.
    always_ff @(posedge CLK) begin
        if (wr_en && (state_q == IDLE) && (wr_addr < IDX_W'(NUM_POINTS))) begin
            mem[wr_addr] <= {wr_x, wr_y};
        end
    end

    // idx reaches NUM_POINTS at the end of SEND; keep the read in range.
    assign rd_idx = (idx_q < IDX_W'(NUM_POINTS)) ? idx_q : '0;
    assign rd_pt  = mem[rd_idx];
    assign pt0    = mem[0];

    laser_cover_chk u_cover_chk (
        .pt      (rd_pt),
        .c1      (c1_q),
        .c2      (c2_q),
        .covered (covered)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            score_q   <= '0;
            timeout_q <= 1'b0;
            c1_q      <= '0;
            c2_q      <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            score_q   <= score_d;
            timeout_q <= timeout_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        score_d   = score_q;
        timeout_d = timeout_q;
        c1_d      = c1_q;
        c2_d      = c2_q;

        unique case (state_q)
            IDLE: begin
                x_d = '0;
                y_d = '0;
                if (start) begin
                    // Point 0 goes out in the very next cycle.
                    x_d       = pt0.x;
                    y_d       = pt0.y;
                    idx_d     = IDX_W'(1);
                    timeout_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (idx_q == IDX_W'(NUM_POINTS)) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    x_d   = rd_pt.x;
                    y_d   = rd_pt.y;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                if (DONE) begin
                    c1_d    = {C1X, C1Y};
                    c2_d    = {C2X, C2Y};
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SCORE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    score_d   = '0;
                    state_d   = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCORE: begin
                acc_d = acc_q + 6'(covered);
                if (idx_q == IDX_W'(NUM_POINTS - 1)) begin
                    score_d = acc_q + 6'(covered);
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign busy        = (state_q == SEND) || (state_q == WAIT) || (state_q == SCORE);
    assign score       = score_q;
    assign score_valid = (state_q == REPORT);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_laser_feeder.sv
// Self-checking bench for laser_feeder: directed frames from the test plan plus
// randomized point sets scored by a plain-arithmetic reference model.
module tb_laser_feeder;

    localparam int NPTS    = 40;
    localparam int TIMEOUT = 4096;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic       start = 1'b0;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] C1X = '0;
    logic [3:0] C1Y = '0;
    logic [3:0] C2X = '0;
    logic [3:0] C2Y = '0;
    logic       DONE = 1'b0;
    logic       busy;
    logic [5:0] score;
    logic       score_valid;
    logic       timeout;

    laser_feeder #(.TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .start       (start),
        .X           (X),
        .Y           (Y),
        .C1X         (C1X),
        .C1Y         (C1Y),
        .C2X         (C2X),
        .C2Y         (C2Y),
        .DONE        (DONE),
        .busy        (busy),
        .score       (score),
        .score_valid (score_valid),
        .timeout     (timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int mx [NPTS];
    int my [NPTS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: count points whose squared distance to either centre is <= 16.
    function automatic int model_score(input int c1x, input int c1y, input int c2x,
                                       input int c2y);
        int cnt = 0;
        for (int i = 0; i < NPTS; i++) begin
            int d1 = (mx[i] - c1x) * (mx[i] - c1x) + (my[i] - c1y) * (my[i] - c1y);
            int d2 = (mx[i] - c2x) * (mx[i] - c2x) + (my[i] - c2y) * (my[i] - c2y);
            if (d1 <= 16 || d2 <= 16) cnt++;
        end
        return cnt;
    endfunction

    task automatic load_all();
        for (int i = 0; i < NPTS; i++) begin
            @(negedge CLK);
            wr_en   = 1'b1;
            wr_addr = 6'(i);
            wr_x    = 4'(mx[i]);
            wr_y    = 4'(my[i]);
        end
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // Pulses start and checks all 40 streamed points; returns in the first WAIT
    // cycle. With misuse set, pulses wr_en and start in the middle of SEND.
    task automatic stream_frame(input string tag, input bit misuse);
        int errs = 0;
        @(negedge CLK);
        check({tag, " idle_x"}, X, 0);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check({tag, " busy_rise"}, busy, 1);
        for (int k = 0; k < NPTS; k++) begin
            if (k > 0) @(negedge CLK);
            if (X !== 4'(mx[k]) || Y !== 4'(my[k])) errs++;
            if (misuse && k == 5) begin
                wr_en   = 1'b1;
                wr_addr = 6'd3;
                wr_x    = ~4'(mx[3]);
                wr_y    = ~4'(my[3]);
                start   = 1'b1;
            end
            if (misuse && k == 6) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
        end
        check({tag, " stream_errs"}, errs, 0);
        @(negedge CLK);
        check({tag, " xy_after"}, {X, Y}, 0);
        check({tag, " busy_wait"}, busy, 1);
    endtask

    task automatic run_frame(input string tag, input int c1x, input int c1y, input int c2x,
                             input int c2y, input int delay, input bit misuse,
                             input int exp_const);
        int  n  = 0;
        bit  ok = 0;
        int  exp;
        exp = model_score(c1x, c1y, c2x, c2y);
        stream_frame(tag, misuse);
        C1X = 4'(c1x);
        C1Y = 4'(c1y);
        C2X = 4'(c2x);
        C2Y = 4'(c2y);
        repeat (delay) @(negedge CLK);
        DONE = 1'b1;
        while (n < 200 && !ok) begin
            @(negedge CLK);
            DONE = 1'b0;
            n++;
            if (score_valid) ok = 1;
        end
        check({tag, " latency"}, n, 41);
        check({tag, " score"}, score, exp);
        if (exp_const >= 0) check({tag, " score_const"}, score, exp_const);
        check({tag, " timeout"}, timeout, 0);
        check({tag, " busy_drop"}, busy, 0);
        @(negedge CLK);
        check({tag, " valid_pulse"}, score_valid, 0);
        check({tag, " score_hold"}, score, exp);
    endtask

    initial begin
        int n;
        bit ok;
        int busy_seen;
        int valid_seen;

        // Reset values while RST is held.
        #2;
        check("rst_xy", {X, Y}, 0);
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_valid", score_valid, 0);
        check("rst_timeout", timeout, 0);
        @(negedge CLK);
        RST = 1'b0;

        // All points at (8,8).
        for (int i = 0; i < NPTS; i++) begin
            mx[i] = 8;
            my[i] = 8;
        end
        load_all();
        run_frame("all88", 8, 8, 0, 0, 0, 0, 40);

        // Two clusters.
        for (int i = 0; i < NPTS; i++) begin
            mx[i] = (i < 20) ? 0 : 15;
            my[i] = (i < 20) ? 0 : 15;
        end
        load_all();
        run_frame("split_both", 0, 0, 15, 15, 2, 0, 40);
        run_frame("split_one", 0, 0, 0, 0, 1, 0, 20);

        // Radius boundary: 16 covered, 17 not.
        for (int i = 0; i < NPTS; i++) begin
            mx[i] = 0;
            my[i] = 15;
        end
        mx[0] = 12; my[0] = 8;
        mx[1] = 12; my[1] = 9;
        load_all();
        run_frame("radius", 8, 8, 8, 8, 0, 0, 1);

        // Timeout: DONE never raised.
        stream_frame("tmo", 0);
        n  = 0;
        ok = 0;
        while (n < TIMEOUT + 10 && !ok) begin
            @(negedge CLK);
            n++;
            if (score_valid) ok = 1;
        end
        check("tmo latency", n, TIMEOUT);
        check("tmo flag", timeout, 1);
        check("tmo score", score, 0);
        check("tmo busy", busy, 0);
        @(negedge CLK);
        check("tmo flag_hold", timeout, 1);

        // Misuse: write and start during SEND are ignored.
        run_frame("misuse", 8, 8, 8, 8, 0, 1, 1);
        busy_seen = 0;
        repeat (60) begin
            @(negedge CLK);
            if (busy) busy_seen++;
        end
        check("misuse no_second_frame", busy_seen, 0);
        run_frame("misuse_mem", 8, 8, 0, 15, 3, 0, -1);

        // Out-of-range address write in IDLE is dropped.
        @(negedge CLK);
        wr_en   = 1'b1;
        wr_addr = 6'd45;
        wr_x    = 4'd15;
        wr_y    = 4'd15;
        @(negedge CLK);
        wr_en = 1'b0;
        run_frame("addr45", 8, 8, 0, 15, 0, 0, -1);

        // Reset in the middle of SEND.
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (16) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst xy", {X, Y}, 0);
        check("midrst busy", busy, 0);
        check("midrst score", score, 0);
        @(negedge CLK);
        RST        = 1'b0;
        busy_seen  = 0;
        valid_seen = 0;
        repeat (120) begin
            @(negedge CLK);
            if (busy) busy_seen++;
            if (score_valid) valid_seen++;
        end
        check("midrst no_busy", busy_seen, 0);
        check("midrst no_valid", valid_seen, 0);
        run_frame("after_rst", 12, 8, 0, 15, 0, 0, -1);

        // Randomized point sets and centres.
        for (int r = 0; r < 5; r++) begin
            int cx1 = $urandom_range(15);
            int cy1 = $urandom_range(15);
            int cx2 = $urandom_range(15);
            int cy2 = $urandom_range(15);
            for (int i = 0; i < NPTS; i++) begin
                // Cluster half the points near circle 1 so scores are non-trivial.
                if (i % 2 == 0) begin
                    mx[i] = (cx1 + $urandom_range(6) >= 3) ? ((cx1 + $urandom_range(6) - 3) % 16)
                                                           : 0;
                    my[i] = (cy1 + $urandom_range(6) >= 3) ? ((cy1 + $urandom_range(6) - 3) % 16)
                                                           : 0;
                end else begin
                    mx[i] = $urandom_range(15);
                    my[i] = $urandom_range(15);
                end
            end
            load_all();
            run_frame($sformatf("rand%0d", r), cx1, cy1, cx2, cy2, $urandom_range(6), 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
